// File: rtl/seg_rx_pkg.sv
// Shared types and constants for the multiplexed 7-segment bus receiver:
// FSM state type, sample-word width and the active-low hex segment patterns.
package seg_rx_pkg;

  localparam int SAMPLE_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_WAIT_CHANGE
  } seg_state_t;

  // Segment order is {a,b,c,d,e,f,g}; 0 = lit.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational 7-segment pattern to hex nibble decoder; hit is low for
// any pattern that is not one of the sixteen hex glyphs (blank included).
module seg_pattern_decoder
  import seg_rx_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_bus_receiver.sv
// Recovers four hex digits from a multiplexed, active-low 7-segment display bus.
// Optional saturating error counter enabled by defining SEG_RX_ERRCNT_EN.
module segment_bus_receiver
  import seg_rx_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        char_error,
  output logic        link_lost,
  output logic [7:0]  err_count
);

  localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCNT_W-1:0] STABLE_MAX = SCNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT_CYCLES);
  localparam seg_state_t START_ST = (STABLE_CYCLES == 1) ? ST_CAPTURE : ST_SETTLE;

  logic [SAMPLE_W-1:0] pins;
  logic [SAMPLE_W-1:0] sync1_q, sync2_q;

  seg_state_t          state_q, state_d;
  logic [SCNT_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [SAMPLE_W-1:0] word_q, word_d;
  logic [15:0]         digits_q, digits_d;
  logic [3:0]          seen_q, seen_d;
  logic                frame_valid_q, frame_valid_d;
  logic                char_error_q, char_error_d;
  logic [TO_W-1:0]     to_q, to_d;

  logic [3:0] sample_an_low, word_an_low;
  logic       sample_valid;
  logic [3:0] dec_nibble;
  logic       dec_hit;

  assign pins = {an3, an2, an1, an0, a, b, c, d, e, f, g};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
    end
  end

  // A sample is usable only when exactly one anode is driven low.
  assign sample_an_low = ~sync2_q[10:7];
  assign sample_valid  = (sample_an_low != 4'h0) &&
                         ((sample_an_low & (sample_an_low - 4'h1)) == 4'h0);
  assign word_an_low   = ~word_q[10:7];

  seg_pattern_decoder u_dec (
    .pattern (word_q[6:0]),
    .nibble  (dec_nibble),
    .hit     (dec_hit)
  );

  always_comb begin
    state_d       = state_q;
    stab_cnt_d    = stab_cnt_q;
    word_d        = word_q;
    digits_d      = digits_q;
    char_error_d  = 1'b0;
    frame_valid_d = (seen_q == 4'hF);
    seen_d        = (seen_q == 4'hF) ? 4'h0 : seen_q;
    to_d          = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (sample_valid) begin
          word_d     = sync2_q;
          stab_cnt_d = SCNT_W'(1);
          state_d    = START_ST;
        end
      end
      ST_SETTLE: begin
        if (!sample_valid) begin
          state_d = ST_IDLE;
        end else if (sync2_q != word_q) begin
          word_d     = sync2_q;
          stab_cnt_d = SCNT_W'(1);
          state_d    = START_ST;
        end else begin
          stab_cnt_d = stab_cnt_q + SCNT_W'(1);
          if (stab_cnt_q + SCNT_W'(1) == STABLE_MAX) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        to_d = '0;
        if (dec_hit) begin
          for (int i = 0; i < 4; i++) begin
            if (word_an_low[i]) digits_d[i*4 +: 4] = dec_nibble;
          end
          seen_d = seen_d | word_an_low;
        end else begin
          char_error_d = 1'b1;
        end
        state_d = ST_WAIT_CHANGE;
      end
      default: begin
        if (sync2_q != word_q) begin
          if (sample_valid) begin
            word_d     = sync2_q;
            stab_cnt_d = SCNT_W'(1);
            state_d    = START_ST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      stab_cnt_q    <= '0;
      word_q        <= '1;
      digits_q      <= 16'h0000;
      seen_q        <= 4'h0;
      frame_valid_q <= 1'b0;
      char_error_q  <= 1'b0;
      to_q          <= '0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      word_q        <= word_d;
      digits_q      <= digits_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      char_error_q  <= char_error_d;
      to_q          <= to_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = frame_valid_q;
  assign char_error  = char_error_q;
  assign link_lost   = (to_q == TO_MAX);

`ifdef SEG_RX_ERRCNT_EN
  logic [7:0] err_q, err_d;

  // Counts alongside the char_error register so both appear in the same cycle.
  assign err_d = (char_error_d && (err_q != 8'hFF)) ? err_q + 8'h01 : err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 8'h00;
    else       err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/segment_bus_receiver.md
SEGMENT_BUS_RECEIVER -- requirements
Module: segment_bus_receiver

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, giving the number of consecutive identical samples required before a digit is captured.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the number of cycles without a valid capture before link loss is declared.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 an3, an2, an1, an0  input  1 each  multiplexed anode lines, active-low, asynchronous to clk.
REQ-006 a, b, c, d, e, f, g  input  1 each  segment lines, active-low (0 = lit), asynchronous to clk.
REQ-007 digits  output  16  captured hex characters: [15:12]=an3 digit … [3:0]=an0 digit.
REQ-008 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-009 char_error  output  1  one-cycle pulse on capture of a non-hex segment pattern.
REQ-010 link_lost  output  1  level, high while no capture has occurred for TIMEOUT_CYCLES cycles.
REQ-011 err_count  output  8  saturating count of char_error pulses (see Configuration).

Function
REQ-012 All anode and segment inputs SHALL pass through a two-flop synchronizer; all further logic SHALL use only synchronized values.
REQ-013 The sample word is {an3..an0, a..g} (11 bits). Valid = exactly one anode low.
REQ-014 FSM states: IDLE, SETTLE, CAPTURE, WAIT_CHANGE.
REQ-015 IDLE: on a valid sample -> SETTLE, stability counter = 1.
REQ-016 SETTLE: same sample -> counter++; differing valid sample -> counter = 1 and stay; invalid sample -> IDLE. At counter == STABLE_CYCLES -> CAPTURE.
REQ-017 CAPTURE (one cycle): decode segments to nibble and write it into the digits slot selected by the active anode; a non-hex pattern (including blank 7'b1111111) SHALL pulse char_error and leave the slot unchanged; then -> WAIT_CHANGE.
REQ-018 WAIT_CHANGE: stay while the sample equals the captured word; on any change -> IDLE (invalid) or SETTLE with counter = 1 (valid).
REQ-019 Decoding uses standard active-low hex patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 (order abcdefg).
REQ-020 A 4-bit seen mask SHALL set the bit for each anode captured with a hex pattern; when all four bits are set, frame_valid SHALL pulse in the next cycle and the mask SHALL clear in that same cycle.
REQ-021 Recapturing the same anode before the mask completes SHALL overwrite that slot and SHALL NOT pulse frame_valid.
REQ-022 The timeout counter SHALL clear on every CAPTURE and saturate at TIMEOUT_CYCLES; link_lost = (counter == TIMEOUT_CYCLES); link_lost SHALL deassert in the cycle after the next CAPTURE.
REQ-023 Latency: a stable input change SHALL appear on digits 2 (sync) + STABLE_CYCLES + 1 cycles after it reaches the pins.

Reset
REQ-024 On reset: FSM = IDLE, synchronizers = all ones, digits = 16'h0000, seen mask = 0, frame_valid = 0, char_error = 0, timeout counter = 0, link_lost = 0, err_count = 0.
REQ-025 Reset asserted mid-capture SHALL abort immediately; no partial slot write.

Configuration
REQ-026 With SEG_RX_ERRCNT_EN defined, err_count SHALL increment on each char_error and saturate at 255.
REQ-027 Without SEG_RX_ERRCNT_EN, err_count SHALL be constant 8'h00 and no counter register SHALL exist.

Structure
REQ-028 Shared package seg_rx_pkg SHALL hold the FSM state type, the 16 segment-pattern constants, and the sample-word width constant.
REQ-029 Segment-to-nibble decoding SHALL be a combinational sub-module seg_pattern_decoder (inputs: 7-bit pattern; outputs: 4-bit nibble and hit flag).

Verification
REQ-030 Drive an0 low, segments 0000001, held for 30 cycles -> digits[3:0]=0, no char_error.
REQ-031 Cycle an0..an3 with patterns 1, 2, A, F (each held for 40 cycles) -> digits=16'hFA21, exactly one frame_valid pulse.
REQ-032 Glitch the segments to a new value for 10 cycles (less than STABLE_CYCLES), then restore -> digits unchanged.
REQ-033 Hold an1 low with blank 1111111 -> one char_error pulse, digits[7:4] unchanged, err_count=1 when the macro is enabled.
REQ-034 Hold all anodes high for TIMEOUT_CYCLES+5 cycles -> link_lost=1; then apply a valid stable digit -> link_lost=0 after capture.
REQ-035 Assert reset during SETTLE -> all outputs at their reset values, FSM=IDLE.
